// File: rtl/booth_mult_unit.sv
// booth_mult_unit: sequential signed radix-2 Booth multiplier; the product lands in Hi/Lo.
// Optional feature: define MULT_ZERO_SKIP_EN so that zero-operand multiplies finish in one cycle.
module booth_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MultStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MultBusy,
    output logic             MultDone
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [WIDTH:0] m_reg;
    logic [PW-1:0]  p_reg;
    logic [CW-1:0]  count;
    logic [WIDTH:0] upper, upper_op;
    logic [PW-1:0]  p_sum, p_step;
    logic           accept, last, zero_skip;

    // Accept a start only in IDLE; iteration WIDTH is the last one.
    assign accept = (state == IDLE) && MultStart;
    assign last   = count == CW'(WIDTH - 1);

`ifdef MULT_ZERO_SKIP_EN
    assign zero_skip = (A == '0) || (B == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // One Booth step: add/subtract M on the sign-extended upper half, then arithmetic shift right.
    always_comb begin
        upper    = p_reg[PW-1:WIDTH+1];
        upper_op = (p_reg[1:0] == 2'b01) ? upper + m_reg :
                   (p_reg[1:0] == 2'b10) ? upper - m_reg : upper;
        p_sum    = {upper_op, p_reg[WIDTH:0]};
        p_step   = {p_sum[PW-1], p_sum[PW-1:1]};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        MultBusy   = 1'b0;
        MultDone   = 1'b0;
        case (state)
            IDLE: state_next = accept ? (zero_skip ? DONE : RUN) : IDLE;
            RUN: begin
                MultBusy   = 1'b1;
                state_next = last ? DONE : RUN;
            end
            DONE: begin
                MultBusy   = 1'b1;
                MultDone   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result load; Hi/Lo change only at completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_reg <= '0;
            p_reg <= '0;
            count <= '0;
            Hi    <= '0;
            Lo    <= '0;
        end else if (accept) begin
            m_reg <= {A[WIDTH-1], A};
            p_reg <= {{(WIDTH + 1){1'b0}}, B, 1'b0};
            count <= '0;
            if (zero_skip) begin
                Hi <= '0;
                Lo <= '0;
            end
        end else if (state == RUN) begin
            p_reg <= p_step;
            count <= count + CW'(1);
            if (last)
                {Hi, Lo} <= p_step[2*WIDTH:1];
        end
    end
endmodule

// File: tb/tb_booth_mult_unit.sv
// tb_booth_mult_unit: vector table plus corner sequences, products checked through a scoreboard.
module tb_booth_mult_unit;
    localparam int W = 32;
`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           MultStart = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic [W-1:0]   Hi, Lo;
    logic           MultBusy, MultDone;
    int             vectors = 0;
    int             miscompares = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] last_res = '0;
    vec_t           vecs[10];

    booth_mult_unit #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .MultStart(MultStart),
        .A(A),
        .B(B),
        .Hi(Hi),
        .Lo(Lo),
        .MultBusy(MultBusy),
        .MultDone(MultDone)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x, y;
        x = {{W{a[W-1]}}, a};
        y = {{W{b[W-1]}}, b};
        return x * y;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        return (ZS && (a == '0 || b == '0)) ? 1 : W + 1;
    endfunction

    // Every completion pops the oldest expected product.
    always @(negedge clock) begin
        if (!reset && MultDone) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got MultDone=1 expected no pending operation");
            end else begin
                logic [2*W-1:0] e;
                e = sb.pop_front();
                check("product", {Hi, Lo}, e);
                last_res = e;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke,
                         output int lat, output int busy);
        logic [2*W-1:0] hold;
        hold = last_res;
        @(negedge clock);
        A = a;
        B = b;
        MultStart = 1'b1;
        sb.push_back(model(a, b));
        lat = 0;
        busy = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                MultStart = 1'b0;
                A = $urandom;
                B = $urandom;
            end
            if (poke != 0 && lat == poke) begin
                MultStart = 1'b1;
                A = 32'h9;
                B = 32'h7;
            end
            if (poke != 0 && lat == poke + 1)
                MultStart = 1'b0;
            if (MultBusy)
                busy++;
            if (lat == 5 && !MultDone)
                check("hold", {Hi, Lo}, hold);
        end while (!MultDone && lat < 100);
        if (!MultDone) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no MultDone after %0d cycles expected %0d", lat, exp_lat(a, b));
            sb.delete();
        end
        @(negedge clock);
        check("done_pulse", {63'b0, MultDone}, 64'd0);
        check("idle_busy", {63'b0, MultBusy}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat, busy;
        vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[6] = '{32'd0, 32'h0000_1234, 64'h0000_0000_0000_0000};
        vecs[7] = '{32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678};
        vecs[8] = '{32'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        repeat (3) @(negedge clock);
        check("rst_hilo", {Hi, Lo}, 64'd0);
        check("rst_busy", {63'b0, MultBusy}, 64'd0);
        check("rst_done", {63'b0, MultDone}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            check("model", model(vecs[i].a, vecs[i].b), vecs[i].p);
            do_op(vecs[i].a, vecs[i].b, 0, lat, busy);
            check("latency", 64'(lat), 64'(exp_lat(vecs[i].a, vecs[i].b)));
            check("busy_cycles", 64'(busy), 64'(exp_lat(vecs[i].a, vecs[i].b)));
        end

        @(negedge clock);
        A = 32'h1234;
        B = 32'h5678;
        MultStart = 1'b1;
        @(negedge clock);
        MultStart = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_hilo", {Hi, Lo}, 64'd0);
        check("abort_busy", {63'b0, MultBusy}, 64'd0);
        check("abort_done", {63'b0, MultDone}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        last_res = '0;
        repeat (40) @(negedge clock);
        check("abort_idle", {63'b0, MultBusy}, 64'd0);
        do_op(32'hFFFF_0001, 32'h0000_7777, 0, lat, busy);
        check("post_abort_lat", 64'(lat), 64'(W + 1));

        do_op(32'd3, 32'd5, 10, lat, busy);
        check("restart_ignored_lat", 64'(lat), 64'(W + 1));

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = (i < 3) ? W'($urandom_range(0, 255)) - 32'd128 : $urandom;
            do_op(ra, rb, 0, lat, busy);
            check("rand_latency", 64'(lat), 64'(exp_lat(ra, rb)));
        end

        begin
            int t, seen, prev_t;
            t = 0;
            seen = 0;
            prev_t = 0;
            @(negedge clock);
            A = 32'd3;
            B = 32'd5;
            MultStart = 1'b1;
            repeat (3) sb.push_back(model(32'd3, 32'd5));
            while (seen < 3 && t < 200) begin
                @(negedge clock);
                t++;
                if (MultDone) begin
                    if (seen == 0)
                        check("stream_first", 64'(t), 64'(W + 1));
                    else
                        check("stream_period", 64'(t - prev_t), 64'(W + 2));
                    prev_t = t;
                    seen++;
                    if (seen == 3)
                        MultStart = 1'b0;
                end
            end
            if (seen < 3) begin
                vectors++;
                miscompares++;
                $display("FAIL stream_timeout: got %0d results expected 3", seen);
                MultStart = 1'b0;
                sb.delete();
            end
            repeat (2) @(negedge clock);
            check("stream_stop", {63'b0, MultBusy}, 64'd0);
        end

        repeat (3) @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
